// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch front end. It keeps at most one instruction-memory
//   request outstanding and loads the returned word into the IF/ID register.
//   If decode is stalled when a word returns, the word goes into a one-entry
//   skid register. A redirect flushes the fetch path and restarts fetching at
//   a new address. A redirect that arrives while a read is still in flight
//   waits in DROP until that read's data comes back and throws the data away.
//
//   Ports
//     clk, rst_n             clock; asynchronous active-low reset
//     imem_req, imem_addr    request to instruction memory (word aligned)
//     imem_ack, imem_rdata   read completion and its data
//     stall                  decode cannot take the IF/ID word this cycle
//     redirect, redirect_pc  flush and refetch from redirect_pc (low bits forced to 0)
//     if_valid, if_instr     IF/ID register contents
//     if_opcode              if_instr[31:26]
//     if_pc4                 fetch address + 4 of if_instr (link value)
//
//   state | meaning
//   IDLE  | after reset; no request issued yet, stray acks ignored
//   REQ   | request at imem_addr outstanding
//   HOLD  | returned word parked in skid, waiting for decode; no request
//   DROP  | redirected while a request is in flight; its data is discarded
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc4
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        if_valid_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc4_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc4_q;

    logic [31:0] pc4_d;
    logic [31:0] redir_pc_d;
    logic        ifid_free_d;

    always_comb begin
        pc4_d       = pc_q + 32'd4;     // wraps modulo 2^32
        redir_pc_d  = {redirect_pc[31:2], 2'b00};
        // IF/ID can be overwritten this edge if it is empty or being consumed
        ifid_free_d = !if_valid_q || !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc4_q     <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else if (redirect) begin
            // Redirect overrides stall and ack; an ack in this cycle is dropped.
            if_valid_q   <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            pc_q         <= redir_pc_d;
            if ((state_q == REQ || state_q == DROP) && !imem_ack) begin
                // Request still in flight: keep req/addr stable and wait it out.
                state_q <= DROP;
            end else begin
                state_q     <= REQ;
                imem_req_q  <= 1'b1;
                imem_addr_q <= redir_pc_d;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    imem_req_q  <= 1'b1;
                    imem_addr_q <= pc_q;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_q <= pc4_d;
                        if (ifid_free_d) begin
                            if_instr_q  <= imem_rdata;
                            if_pc4_q    <= pc4_d;
                            if_valid_q  <= 1'b1;
                            imem_addr_q <= pc4_d;
                        end else begin
                            skid_instr_q <= imem_rdata;
                            skid_pc4_q   <= pc4_d;
                            imem_req_q   <= 1'b0;
                            state_q      <= HOLD;
                        end
                    end else if (ifid_free_d) begin
                        if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_instr_q  <= skid_instr_q;
                        if_pc4_q    <= skid_pc4_q;
                        if_valid_q  <= 1'b1;
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_q     <= REQ;
                        imem_addr_q <= pc_q;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[31:26];
    assign if_pc4    = if_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: dut0 (RESET_PC=0) runs a table of cycle vectors and
// hand sequences for redirect-while-outstanding and async reset; dut1
// (RESET_PC=FFFF_FFFC) checks address wrap. The memory model answers each
// request one cycle after it appears (extra wait cycles via lat) with
// data = ~address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_nv;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;

    logic [1:0]  m_req;
    logic [1:0]  m_ack;
    logic [31:0] m_addr [2];
    logic [31:0] m_rdata [2];
    logic [1:0]  if_valid_v;
    logic [31:0] if_instr_v [2];
    logic [5:0]  if_opcode_v [2];
    logic [31:0] if_pc4_v [2];

    int          lat;
    logic        man_mode;
    logic [31:0] man_rdata;
    int          wcnt [2];

    int n_chk = 0;
    int n_err = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_nv[0]),
        .imem_req(m_req[0]), .imem_addr(m_addr[0]),
        .imem_ack(m_ack[0]), .imem_rdata(m_rdata[0]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid_v[0]), .if_instr(if_instr_v[0]),
        .if_opcode(if_opcode_v[0]), .if_pc4(if_pc4_v[0])
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_nv[1]),
        .imem_req(m_req[1]), .imem_addr(m_addr[1]),
        .imem_ack(m_ack[1]), .imem_rdata(m_rdata[1]),
        .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .if_valid(if_valid_v[1]), .if_instr(if_instr_v[1]),
        .if_opcode(if_opcode_v[1]), .if_pc4(if_pc4_v[1])
    );

    // Memory model: ack arrives after the request has been visible for lat+1 cycles.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0 && man_mode) begin
                m_ack[k]   = 1'b1;
                m_rdata[k] = man_rdata;
            end else if (!rst_nv[k]) begin
                m_ack[k] = 1'b0;
                wcnt[k]  = 0;
            end else if (m_ack[k]) begin
                m_ack[k] = 1'b0;
                wcnt[k]  = m_req[k] ? 1 : 0;
            end else if (m_req[k]) begin
                if (wcnt[k] >= lat + 1) begin
                    m_ack[k]   = 1'b1;
                    m_rdata[k] = ~m_addr[k];
                end else begin
                    wcnt[k] = wcnt[k] + 1;
                end
            end else begin
                wcnt[k] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_req"},    32'(m_req[0]),       32'h0);
        chk({tag, "_addr"},   m_addr[0],           32'h0);
        chk({tag, "_valid"},  32'(if_valid_v[0]),  32'h0);
        chk({tag, "_instr"},  if_instr_v[0],       32'h0);
        chk({tag, "_pc4"},    if_pc4_v[0],         32'h0);
        chk({tag, "_opcode"}, 32'(if_opcode_v[0]), 32'h0);
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc4;
    } vec_t;

    vec_t        tv [21];
    logic [31:0] exp_instr;
    logic        ok;

    initial begin
        tv[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tv[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tv[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h004};
        tv[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h004};
        tv[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h008};
        tv[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h008};
        tv[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h00C};
        tv[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h00C};
        tv[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h00C};
        tv[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'h00C};
        tv[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h010};
        tv[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b0, 32'h010};
        tv[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h014};
        tv[13] = '{1'b1, 1'b1, 32'h203, 1'b1, 32'h014, 1'b0, 32'h014};
        tv[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        tv[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        tv[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h204};
        tv[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h204};
        tv[18] = '{1'b0, 1'b1, 32'h302, 1'b1, 32'h300, 1'b0, 32'h000};
        tv[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h000};
        tv[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h304};

        rst_nv = 2'b00;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = 32'h0;
        lat = 0; man_mode = 1'b0; man_rdata = 32'h0;
        m_ack = 2'b00; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        wcnt[0] = 0; wcnt[1] = 0;

        // Reset values before any clock edge, and still after edges in reset.
        #2;
        chk_reset0("rst_noclk");
        repeat (2) @(posedge clk);
        #2;
        chk_reset0("rst_clk");
        @(negedge clk);
        rst_nv[0] = 1'b1;

        // Table: inputs for one cycle, outputs checked after the next edge.
        for (int i = 0; i < 21; i++) begin
            stall       = tv[i].stall;
            redirect    = tv[i].redirect;
            redirect_pc = tv[i].rpc;
            @(posedge clk);
            #2;
            chk($sformatf("tv%0d_req", i),   32'(m_req[0]),      32'(tv[i].req));
            chk($sformatf("tv%0d_valid", i), 32'(if_valid_v[0]), 32'(tv[i].valid));
            if (tv[i].req)
                chk($sformatf("tv%0d_addr", i), m_addr[0], tv[i].addr);
            if (tv[i].valid) begin
                exp_instr = ~(tv[i].pc4 - 32'd4);
                chk($sformatf("tv%0d_pc4", i),    if_pc4_v[0],         tv[i].pc4);
                chk($sformatf("tv%0d_instr", i),  if_instr_v[0],       exp_instr);
                chk($sformatf("tv%0d_opcode", i), 32'(if_opcode_v[0]), 32'(exp_instr[31:26]));
            end
        end
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Async reset in the middle of an ack cycle.
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (m_ack[0]) begin ok = 1'b1; break; end
        end
        chk("ack_seen_timeout", 32'(ok), 32'h1);
        #1;
        rst_nv[0] = 1'b0;
        #1;
        chk_reset0("rst_midack");

        // Stray ack while in reset and right after release must be ignored.
        man_mode  = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #2;
        rst_nv[0] = 1'b1;
        @(negedge clk);
        man_mode = 1'b0;
        @(posedge clk);
        #2;
        chk("restart_req",   32'(m_req[0]),      32'h1);
        chk("restart_addr",  m_addr[0],          32'h0);
        chk("restart_valid", 32'(if_valid_v[0]), 32'h0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (if_valid_v[0]) begin ok = 1'b1; break; end
        end
        chk("restart_timeout", 32'(ok), 32'h1);
        chk("restart_pc4",   if_pc4_v[0],   32'h4);
        chk("restart_instr", if_instr_v[0], 32'hFFFF_FFFF);

        // Redirect to 0x103 while the request to 0x8 is outstanding.
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (m_req[0] && m_addr[0] == 32'h8) begin ok = 1'b1; break; end
        end
        chk("req8_timeout", 32'(ok), 32'h1);
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk);
        #2;
        redirect = 1'b0;
        chk("drop_req",   32'(m_req[0]),      32'h1);
        chk("drop_addr",  m_addr[0],          32'h8);
        chk("drop_valid", 32'(if_valid_v[0]), 32'h0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (m_addr[0] == 32'h100) begin ok = 1'b1; break; end
            chk($sformatf("drop_wait%0d_addr", c),  m_addr[0],          32'h8);
            chk($sformatf("drop_wait%0d_valid", c), 32'(if_valid_v[0]), 32'h0);
        end
        chk("drop_timeout", 32'(ok), 32'h1);
        lat = 0;
        chk("refetch_req",   32'(m_req[0]),      32'h1);
        chk("refetch_valid", 32'(if_valid_v[0]), 32'h0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (if_valid_v[0]) begin ok = 1'b1; break; end
        end
        chk("refetch_timeout", 32'(ok), 32'h1);
        chk("refetch_pc4",   if_pc4_v[0],   32'h104);
        chk("refetch_instr", if_instr_v[0], ~32'h100);

        // RESET_PC at the top of the address space wraps to 0.
        @(negedge clk);
        rst_nv[1] = 1'b1;
        @(posedge clk);
        #2;
        chk("wrap_req",   32'(m_req[1]), 32'h1);
        chk("wrap_addr0", m_addr[1],     32'hFFFF_FFFC);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            if (if_valid_v[1]) begin ok = 1'b1; break; end
        end
        chk("wrap_timeout", 32'(ok), 32'h1);
        chk("wrap_pc4",   if_pc4_v[1],   32'h0);
        chk("wrap_instr", if_instr_v[1], 32'h3);
        chk("wrap_addr1", m_addr[1],     32'h0);
        chk("wrap_req1",  32'(m_req[1]), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: imem_req  out  1  instruction-memory request.
REQ-005 SHALL have ports: imem_addr  out  32  request address, word-aligned.
REQ-006 SHALL have ports: imem_ack  in  1  read data valid; completes the outstanding request.
REQ-007 SHALL have ports: imem_rdata  in  32  instruction word, sampled only when imem_ack=1.
REQ-008 SHALL have ports: stall  in  1  decode stage cannot accept the IF/ID word this cycle.
REQ-009 SHALL have ports: redirect  in  1  taken beq/baln/jrsal or jump; flush and refetch.
REQ-010 SHALL have ports: redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-011 SHALL have ports: if_valid  out  1  IF/ID register holds a valid instruction.
REQ-012 SHALL have ports: if_instr  out  32  IF/ID instruction word.
REQ-013 SHALL have ports: if_opcode  out  6  if_instr[31:26], the decoder's opcode input.
REQ-014 SHALL have ports: if_pc4  out  32  fetch address + 4 of if_instr, the link value for baln/jrsal.

Function
REQ-015 SHALL implement states IDLE, REQ, HOLD, DROP; at most one memory request outstanding.
REQ-016 IDLE SHALL move to REQ on the next rising edge, with imem_req=1 and imem_addr=pc.
REQ-017 In REQ and DROP, imem_req SHALL stay 1 and imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-018 The IF/ID register SHALL be "free" when if_valid=0 or stall=0; the consumer takes the word on any edge with if_valid=1 and stall=0.
REQ-019 REQ with imem_ack=1 and IF/ID free: load if_instr=imem_rdata and if_pc4=pc+4, set if_valid=1, set pc=pc+4, and remain in REQ, issuing the next address on the following cycle.
REQ-020 REQ with imem_ack=1 and IF/ID not free: write the word and pc+4 to a one-entry skid register, set pc=pc+4, drop imem_req, and go to HOLD.
REQ-021 REQ with no ack and IF/ID free: clear if_valid.
REQ-022 HOLD with stall=0: move the skid contents into IF/ID with if_valid=1, then go to REQ.
REQ-023 HOLD with stall=1: hold the skid register and IF/ID unchanged.
REQ-024 redirect=1 SHALL take priority over stall and ack: clear if_valid, clear the skid register, and set pc={redirect_pc[31:2],2'b00}.
REQ-025 On redirect, state SHALL go to DROP if a request is outstanding and imem_ack=0; otherwise it goes to REQ.
REQ-026 In DROP, the data returned with imem_ack SHALL be discarded and state goes to REQ with the redirected pc; a further redirect in DROP only updates pc.
REQ-027 An ack in the same cycle as a redirect SHALL be discarded.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 if_opcode SHALL be a combinational slice of if_instr; all other outputs SHALL be registered.
REQ-030 Best-case throughput SHALL be one instruction per 2 cycles for a 1-cycle-ack memory: the request cycle followed by the ack cycle.

Reset
REQ-031 While rst_n=0, regardless of clk: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0, skid cleared.
REQ-032 Reset asserted mid-request SHALL abandon that request; an ack arriving after rst_n deasserts and before the first request SHALL be ignored.

Verification
REQ-033 Reset release with a 1-cycle-ack memory -> requests at 0x0, 0x4, 0x8 -> if_valid pulses carry if_pc4 values 0x4, 0x8, 0xC.
REQ-034 stall=1 while a request is outstanding and if_valid=1 -> ack moves the word to HOLD and imem_req=0 -> on stall=0, IF/ID shows the held word and no word is lost or duplicated.
REQ-035 redirect=1 with redirect_pc=0x0000_0103 while a request to 0x8 is outstanding -> DROP, the 0x8 data is discarded, the next request is 0x0000_0100, and if_valid=0 until its ack.
REQ-036 redirect together with stall=1 and if_valid=1 -> if_valid=0 on the next edge.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first if_pc4=0x0000_0000 and the second request goes to 0x0.
REQ-038 rst_n pulsed low asynchronously mid-ack -> all outputs return to reset values immediately, and fetch restarts at RESET_PC.
